// File: rtl/dmanu_pipe.sv
// Table-driven lane permutation crossbar for the load/store datapath.
// Registered output stage with a one-entry skid buffer.
module dmanu_pipe #(
  parameter int NLANE  = 12,
  parameter int DATA_W = 16,
  parameter int SEL_W  = 4,
  parameter int DEPTH  = 8,
  parameter int IDX_W  = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_tblwe,
  input  logic [IDX_W-1:0]        i_tbladdr,
  input  logic [SEL_W*NLANE-1:0]  i_tbldata,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [DATA_W*NLANE-1:0] i_indata,
  input  logic [IDX_W-1:0]        i_tblidx,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [DATA_W*NLANE-1:0] o_outdata,
  output logic                    o_selerr
);

  typedef struct packed {
    logic                    err;
    logic [DATA_W*NLANE-1:0] data;
  } beat_t;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } state_t;

  logic [SEL_W*NLANE-1:0] tbl [DEPTH];
  logic [SEL_W*NLANE-1:0] entry;
  logic [SEL_W-1:0]       sel;
  logic                   hit;
  logic                   accept;
  beat_t                  perm;
  beat_t                  skid;
  state_t                 state;

  assign accept = i_valid & o_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < DEPTH; e++) begin
        for (int j = 0; j < NLANE; j++) begin
          tbl[e][SEL_W*j +: SEL_W] <= SEL_W'(j);
        end
      end
    end else if (i_tblwe) begin
      tbl[i_tbladdr] <= i_tbldata;
    end
  end

  // Out-of-range selectors match no lane, so that lane stays zero.
  always_comb begin
    entry = tbl[i_tblidx];
    sel   = '0;
    hit   = 1'b0;
    perm  = '0;
    for (int j = 0; j < NLANE; j++) begin
      sel = entry[SEL_W*j +: SEL_W];
      hit = 1'b0;
      for (int k = 0; k < NLANE; k++) begin
        if (sel == SEL_W'(k)) begin
          perm.data[DATA_W*j +: DATA_W] = i_indata[DATA_W*k +: DATA_W];
          hit = 1'b1;
        end
      end
      if (!hit) begin
        perm.err = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      o_valid   <= 1'b0;
      o_ready   <= 1'b1;
      o_outdata <= '0;
      o_selerr  <= 1'b0;
      skid      <= '0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            {o_selerr, o_outdata} <= perm;
            o_valid <= 1'b1;
            state   <= ONE;
          end
        end
        ONE: begin
          if (accept && i_ready) begin
            {o_selerr, o_outdata} <= perm;
          end else if (accept) begin
            skid    <= perm;
            o_ready <= 1'b0;
            state   <= FULL;
          end else if (i_ready) begin
            o_valid <= 1'b0;
            state   <= EMPTY;
          end
        end
        FULL: begin
          if (i_ready) begin
            {o_selerr, o_outdata} <= skid;
            o_ready <= 1'b1;
            state   <= ONE;
          end
        end
        default: begin
          state   <= EMPTY;
          o_valid <= 1'b0;
          o_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmanu_pipe.sv
// Bench for dmanu_pipe: vector table plus scoreboarded
// multi-cycle sequences (backpressure, same-cycle write, reset).
module tb_dmanu_pipe;

  localparam int NL = 12;
  localparam int DW = 16;
  localparam int SW = 4;
  localparam int IW = 3;
  localparam int W  = NL*DW;
  localparam int TW = NL*SW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_tblwe;
  logic [IW-1:0] i_tbladdr;
  logic [TW-1:0] i_tbldata;
  logic          i_valid;
  logic          o_ready;
  logic [W-1:0]  i_indata;
  logic [IW-1:0] i_tblidx;
  logic          o_valid;
  logic          i_ready;
  logic [W-1:0]  o_outdata;
  logic          o_selerr;

  dmanu_pipe #(
    .NLANE(NL), .DATA_W(DW), .SEL_W(SW), .DEPTH(8), .IDX_W(IW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_tblwe(i_tblwe), .i_tbladdr(i_tbladdr), .i_tbldata(i_tbldata),
    .i_valid(i_valid), .o_ready(o_ready), .i_indata(i_indata),
    .i_tblidx(i_tblidx), .o_valid(o_valid), .i_ready(i_ready),
    .o_outdata(o_outdata), .o_selerr(o_selerr)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            wr;
    logic [IW-1:0] waddr;
    logic [TW-1:0] wdata;
    logic [IW-1:0] idx;
    logic [W-1:0]  data;
    logic [W-1:0]  exp_data;
    logic          exp_err;
  } vec_t;

  typedef struct {
    logic [W-1:0] d;
    logic         e;
  } exp_t;

  exp_t         q[$];
  int           nvec = 0;
  int           nerr = 0;
  logic [W-1:0] last_out = '0;
  bit           saw_ready_low = 1'b0;

  task automatic chk(input string name, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (!o_ready) saw_ready_low = 1'b1;
      if (o_valid && i_ready) begin
        if (q.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL unexpected_beat: got %h", o_outdata);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("beat_data", o_outdata, e.d);
          chk("beat_err", W'(o_selerr), W'(e.e));
          last_out = e.d;
        end
      end else if (o_valid && q.size() > 0) begin
        chk("stall_data", o_outdata, q[0].d);
        chk("stall_err", W'(o_selerr), W'(q[0].e));
      end
    end
  end

  task automatic send(input logic [IW-1:0] idx, input logic [W-1:0] d,
                      input logic [W-1:0] ed, input logic ee);
    bit done = 1'b0;
    int n = 0;
    i_valid  = 1'b1;
    i_tblidx = idx;
    i_indata = d;
    while (!done && n < 50) begin
      @(negedge clk);
      if (o_ready) begin
        q.push_back('{d: ed, e: ee});
        done = 1'b1;
      end
      @(posedge clk);
      #1;
      n++;
    end
    i_valid = 1'b0;
    if (!done) begin
      nvec++;
      nerr++;
      $display("FAIL send_timeout: got o_ready=%b want 1", o_ready);
    end
  endtask

  task automatic twrite(input logic [IW-1:0] a, input logic [TW-1:0] d);
    i_tblwe   = 1'b1;
    i_tbladdr = a;
    i_tbldata = d;
    @(posedge clk);
    #1;
    i_tblwe = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain", W'(q.size()), '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  vec_t         vt[4];
  logic [W-1:0] base;
  logic [W-1:0] d3;
  logic [W-1:0] rev;
  logic [W-1:0] tmp;
  logic [TW-1:0] tw;

  initial begin
    for (int k = 0; k < NL; k++) begin
      base[DW*k +: DW] = 16'(256 + k);
      d3[DW*k +: DW]   = 16'(16'hB000 + 7*k);
    end

    vt[0] = '{wr: 0, waddr: 0, wdata: '0, idx: 0, data: base,
              exp_data: base, exp_err: 0};

    for (int j = 0; j < NL; j++) begin
      tw[SW*j +: SW]  = 4'(11 - j);
      rev[DW*j +: DW] = 16'(256 + 11 - j);
    end
    vt[1] = '{wr: 1, waddr: 3, wdata: tw, idx: 3, data: base,
              exp_data: rev, exp_err: 0};

    for (int j = 0; j < NL; j++) begin
      tw[SW*j +: SW]  = 4'h2;
      tmp[DW*j +: DW] = (j == 0 || j == 5) ? 16'h0000 : 16'h0102;
    end
    tw[3:0]   = 4'hC;
    tw[23:20] = 4'hF;
    vt[2] = '{wr: 1, waddr: 1, wdata: tw, idx: 1, data: base,
              exp_data: tmp, exp_err: 1};

    for (int j = 0; j < NL; j++) begin
      tmp[DW*j +: DW] = 16'(16'hB000 + 7*(11 - j));
    end
    vt[3] = '{wr: 0, waddr: 0, wdata: '0, idx: 3, data: d3,
              exp_data: tmp, exp_err: 0};

    rst_n     = 1'b0;
    i_tblwe   = 1'b0;
    i_tbladdr = '0;
    i_tbldata = '0;
    i_valid   = 1'b0;
    i_indata  = '0;
    i_tblidx  = '0;
    i_ready   = 1'b1;
    #12;
    chk("rst_valid", W'(o_valid), '0);
    chk("rst_data", o_outdata, '0);
    chk("rst_selerr", W'(o_selerr), '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rst_ready", W'(o_ready), W'(1));

    for (int v = 0; v < 4; v++) begin
      if (vt[v].wr) twrite(vt[v].waddr, vt[v].wdata);
      send(vt[v].idx, vt[v].data, vt[v].exp_data, vt[v].exp_err);
      chk("latency", W'(o_valid), W'(1));
      @(posedge clk);
      #1;
    end
    drain();

    // six tagged beats with a three-cycle downstream stall
    saw_ready_low = 1'b0;
    fork
      begin
        for (int t = 1; t <= 6; t++) begin
          tmp = base;
          tmp[DW-1:0] = 16'(t);
          send(0, tmp, tmp, 1'b0);
        end
      end
      begin
        i_ready = 1'b1;
        repeat (2) begin
          @(posedge clk);
          #1;
        end
        i_ready = 1'b0;
        repeat (3) begin
          @(posedge clk);
          #1;
        end
        i_ready = 1'b1;
      end
    join
    drain();
    chk("ready_dropped", W'(saw_ready_low), W'(1));
    repeat (2) @(posedge clk);
    #1;
    tmp = base;
    tmp[DW-1:0] = 16'd6;
    chk("idle_valid", W'(o_valid), '0);
    chk("idle_hold", o_outdata, tmp);

    // table write and beat on entry 2 in the same cycle
    for (int j = 0; j < NL; j++) begin
      tw[SW*j +: SW]  = 4'h5;
      tmp[DW*j +: DW] = 16'h0105;
    end
    i_tblwe   = 1'b1;
    i_tbladdr = 3'd2;
    i_tbldata = tw;
    send(2, base, base, 1'b0);
    i_tblwe = 1'b0;
    send(2, base, tmp, 1'b0);
    drain();

    // reset while both output registers hold beats
    i_ready = 1'b0;
    send(0, d3, d3, 1'b0);
    send(0, base, base, 1'b0);
    chk("full_ready", W'(o_ready), '0);
    #2;
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("rstmid_valid", W'(o_valid), '0);
    @(posedge clk);
    #3;
    rst_n   = 1'b1;
    i_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("post_valid", W'(o_valid), '0);
    chk("post_ready", W'(o_ready), W'(1));
    chk("post_data", o_outdata, '0);
    send(3, d3, d3, 1'b0);
    chk("post_latency", W'(o_valid), W'(1));
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/dmanu_pipe.md
Name: dmanu_pipe

Overview:
- Parametrised, pipelined successor to the 12-lane data-manipulation crossbar in the load/store datapath.
- Each output lane selects any input lane, as before. Selection now comes from a small writable table of permutation entries, chosen per beat, rather than a single static select word.
- Input and output use valid/ready handshakes. A registered output stage with a skid buffer sustains one beat per cycle under backpressure.
- Sits between the load-table logic and the PE-array input ports.

Parameters:
- NLANE, 12, number of data lanes (input and output); legal range 2..16.
- DATA_W, `DATA_W, bits per lane.
- SEL_W, 4, bits per lane selector; must satisfy 2^SEL_W >= NLANE.
- DEPTH, 8, number of permutation table entries; power of two.
- IDX_W, 3, log2(DEPTH).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_tblwe  in  1  table write enable.
- i_tbladdr  in  IDX_W  table entry to write.
- i_tbldata  in  SEL_W*NLANE  selector word; field j (bits SEL_W*j+:SEL_W) drives output lane j.
- i_valid  in  1  input beat valid.
- o_ready  out  1  block can accept a beat.
- i_indata  in  DATA_W*NLANE  input lanes; lane k at bits DATA_W*k+:DATA_W.
- i_tblidx  in  IDX_W  table entry used for this beat.
- o_valid  out  1  output beat valid.
- i_ready  in  1  downstream accepts the beat.
- o_outdata  out  DATA_W*NLANE  permuted lanes.
- o_selerr  out  1  qualified by o_valid: at least one selector in this beat was >= NLANE.

Behaviour:
- Reset (async assert, sync-released by the surrounding reset tree):
  - o_valid=0, o_outdata=0, o_selerr=0.
  - Skid buffer empty; o_ready=1 once rst_n is high.
  - Every table entry set to identity (field j = j).
- Table write: when i_tblwe=1, entry i_tbladdr takes i_tbldata at the clock edge. Writes are independent of the handshake.
- Transfer rule: a beat is accepted when i_valid & o_ready. It uses the table contents before any write in the same cycle (read-before-write).
- Permutation: output lane j = input lane sel_j, where sel_j = field j of entry i_tblidx.
  - If sel_j >= NLANE, output lane j = 0. This is a deliberate change from the previous clamp-to-last behaviour.
  - o_selerr=1 for that beat if any sel_j >= NLANE.
- Latency: exactly 1 cycle, accepted beat to o_valid, when the output stage is empty or draining.
- Output stage: main register (o_*) plus one skid register.
  - States: EMPTY (main invalid), ONE (main valid, skid empty), FULL (both valid).
  - EMPTY: accept -> ONE.
  - ONE: accept & i_ready -> ONE (main reloaded). Accept & !i_ready -> FULL (beat into skid). !accept & i_ready -> EMPTY.
  - FULL: i_ready -> ONE (skid moves to main). Otherwise hold.
  - o_ready = (state != FULL), registered.
- Ordering: beats leave in acceptance order. No beat is dropped or duplicated.
- o_outdata and o_selerr hold stable while o_valid & !i_ready.
- When o_valid=0, o_outdata holds its last value; it is zero only after reset.
- rst_n low mid-operation: in-flight beats are discarded and the table returns to identity.

Test Plan:
- Reset, no writes, i_tblidx=0, lanes k=16'h0100+k, i_ready=1:
  - o_valid one cycle later.
  - o_outdata lane j = 16'h0100+j.
  - o_selerr=0.
- Write entry 3 = reverse (field j = 11-j), then send beat idx=3, same data: lane j = 16'h0100+(11-j), latency 1.
- Write entry 1 with field 0=4'hC and field 5=4'hF, others = 2; send beat idx=1:
  - lanes 0 and 5 = 0; all other lanes = 16'h0102.
  - o_selerr=1.
- Backpressure: stream 6 beats back-to-back (tag in lane 0 = 1..6), hold i_ready=0 for cycles 2-4:
  - o_ready drops after two beats are buffered.
  - All 6 tags emerge in order; output stable while stalled.
- Same-cycle write entry 2 = all-5 and accept beat idx=2 (entry 2 still identity): that beat uses identity; next beat idx=2 yields every lane = input lane 5.
- Assert rst_n low while FULL:
  - o_valid=0 and o_ready=1 after release.
  - A beat with idx=3 now gets identity mapping.
